// File: rtl/polygon_hit_engine_if.sv
// polygon_hit_engine_if: pixel stream, load control, ROM bus and result
// signals of the polygon hit engine. master = environment, slave = engine.
interface polygon_hit_engine_if #(
   parameter int COORD_W = 11,
   parameter int ROM_AW  = 10,
   parameter int PNUM_W  = 5,
   parameter int COUNT_W = 20
);
   logic [COORD_W-1:0]   x_pixel;
   logic [COORD_W-1:0]   y_pixel;
   logic                 pixel_valid;
   logic                 frame_sync;
   logic                 load_req;
   logic [PNUM_W-1:0]    pattern_num;
   logic                 load_busy;
   logic                 load_done;
   logic                 table_ready;
   logic                 p_enable;
   logic [ROM_AW-1:0]    p_addr;
   logic [4*COORD_W-1:0] p_data;
   logic                 pattern_in;
   logic                 pattern_vld;
   logic [COUNT_W-1:0]   hit_count;

   modport master (
      output x_pixel, y_pixel, pixel_valid, frame_sync,
      output load_req, pattern_num, p_data,
      input  load_busy, load_done, table_ready,
      input  p_enable, p_addr,
      input  pattern_in, pattern_vld, hit_count
   );

   modport slave (
      input  x_pixel, y_pixel, pixel_valid, frame_sync,
      input  load_req, pattern_num, p_data,
      output load_busy, load_done, table_ready,
      output p_enable, p_addr,
      output pattern_in, pattern_vld, hit_count
   );
endinterface

// File: rtl/polygon_hit_engine.sv
// polygon_hit_engine: loads an N_EDGES pattern from ROM into a shadow bank,
// swaps it in on frame_sync, and runs a 3-stage ray-cast parity test.
// Ports: clk, reset (sync, active-high); bus (slave modport) carries
//   x_pixel/y_pixel/pixel_valid/frame_sync in, load_req/pattern_num in,
//   load_busy/load_done/table_ready out, p_enable/p_addr out, p_data in,
//   pattern_in/pattern_vld out, hit_count out.
// Option: POLY_HIT_COUNT_EN builds the per-frame inside-pixel counter;
//   without it hit_count is tied to 0.
module polygon_hit_engine #(
   parameter int N_EDGES    = 30,
   parameter int N_PATTERNS = 20,
   parameter int COORD_W    = 11,
   parameter int ROM_AW     = 10,
   parameter int PNUM_W     = 5,
   parameter int COUNT_W    = 20
) (
   input logic                 clk,
   input logic                 reset,
   polygon_hit_engine_if.slave bus
);
   localparam int DW = COORD_W + 1;
   localparam int PW = 2 * COORD_W + 2;
   localparam int IW = (N_EDGES > 1) ? $clog2(N_EDGES) : 1;

   typedef struct packed {
      logic [COORD_W-1:0] x0;
      logic [COORD_W-1:0] y0;
      logic [COORD_W-1:0] x1;
      logic [COORD_W-1:0] y1;
   } edge_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_e;

   function automatic logic signed [DW-1:0] sdiff(
      input logic [COORD_W-1:0] a,
      input logic [COORD_W-1:0] b
   );
      return $signed({1'b0, a}) - $signed({1'b0, b});
   endfunction

   function automatic logic signed [PW-1:0] smul(
      input logic signed [DW-1:0] a,
      input logic signed [DW-1:0] b
   );
      logic signed [PW-1:0] ea;
      logic signed [PW-1:0] eb;
      ea = a;
      eb = b;
      return ea * eb;
   endfunction

   // ---------------- load FSM ----------------
   state_e            state_q, state_d;
   logic [IW-1:0]     k_q;
   logic [ROM_AW-1:0] base_q, base_d;
   logic              rd_vld_q;
   logic [IW-1:0]     rd_idx_q;
   logic              swap_pend_q;
   logic              table_ready_q;
   logic              start, swap, last_k;
   logic [PNUM_W-1:0] pnum;

   assign pnum   = bus.pattern_num;
   assign start  = (state_q == IDLE) & bus.load_req;
   assign swap   = bus.frame_sync & swap_pend_q;
   assign last_k = (k_q == IW'(N_EDGES - 1));

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.load_req) state_d = FETCH;
         FETCH:   if (last_k) state_d = DRAIN;
         DRAIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.p_enable  = (state_q == FETCH);
      bus.p_addr    = '0;
      if (state_q == FETCH) bus.p_addr = base_q + ROM_AW'(k_q);
      bus.load_busy = (state_q != IDLE);
      bus.load_done = (state_q == DRAIN);
   end

   // Out-of-range pattern numbers fall back to pattern 0.
   always_comb begin
      base_d = '0;
      if (int'(pnum) < N_PATTERNS)
         base_d = ROM_AW'(int'(pnum) * N_EDGES);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         k_q           <= '0;
         base_q        <= '0;
         rd_vld_q      <= 1'b0;
         rd_idx_q      <= '0;
         swap_pend_q   <= 1'b0;
         table_ready_q <= 1'b0;
      end else begin
         k_q      <= (state_q == FETCH && !last_k) ? k_q + IW'(1) : '0;
         rd_vld_q <= (state_q == FETCH);
         rd_idx_q <= k_q;
         if (start) base_q <= base_d;
         if (swap) begin
            swap_pend_q   <= 1'b0;
            table_ready_q <= 1'b1;
         end
         if (start) swap_pend_q <= 1'b0;
         // Set after the swap check, so a frame_sync during DRAIN
         // leaves the new pattern waiting for the next frame.
         if (state_q == DRAIN) swap_pend_q <= 1'b1;
      end
   end

   assign bus.table_ready = table_ready_q;

   // ---------------- edge banks ----------------
   edge_t shadow_q [N_EDGES];
   edge_t active_q [N_EDGES];

   always_ff @(posedge clk) begin
      if (rd_vld_q) shadow_q[rd_idx_q] <= edge_t'(bus.p_data);
      if (swap)     active_q <= shadow_q;
   end

   // ---------------- hit pipeline ----------------
   logic [N_EDGES-1:0]   s1_str_q, s1_pos_q;
   logic signed [DW-1:0] s1_dy_q [N_EDGES];
   logic signed [DW-1:0] s1_dx_q [N_EDGES];
   logic signed [DW-1:0] s1_ex_q [N_EDGES];
   logic signed [DW-1:0] s1_ey_q [N_EDGES];
   logic [N_EDGES-1:0]   s2_str_q, s2_pos_q;
   logic signed [PW-1:0] s2_p1_q [N_EDGES];
   logic signed [PW-1:0] s2_p2_q [N_EDGES];
   logic [N_EDGES-1:0]   hit;
   logic                 v1_q, r1_q, v2_q, r2_q;
   logic                 pattern_vld_q, pattern_in_q;

   always_ff @(posedge clk) begin
      for (int k = 0; k < N_EDGES; k++) begin
         s1_str_q[k] <= (active_q[k].y0 > bus.y_pixel) !=
                        (active_q[k].y1 > bus.y_pixel);
         s1_pos_q[k] <= sdiff(active_q[k].y1, active_q[k].y0) > 0;
         s1_dy_q[k]  <= sdiff(active_q[k].y1, active_q[k].y0);
         s1_dx_q[k]  <= sdiff(active_q[k].x1, active_q[k].x0);
         s1_ex_q[k]  <= sdiff(bus.x_pixel, active_q[k].x0);
         s1_ey_q[k]  <= sdiff(bus.y_pixel, active_q[k].y0);
         s2_str_q[k] <= s1_str_q[k];
         s2_pos_q[k] <= s1_pos_q[k];
         s2_p1_q[k]  <= smul(s1_ex_q[k], s1_dy_q[k]);
         s2_p2_q[k]  <= smul(s1_dx_q[k], s1_ey_q[k]);
      end
   end

   always_comb begin
      hit = '0;
      for (int k = 0; k < N_EDGES; k++)
         hit[k] = s2_str_q[k] & (s2_pos_q[k] ?
                  (s2_p1_q[k] < s2_p2_q[k]) :
                  (s2_p1_q[k] > s2_p2_q[k]));
   end

   // table_ready travels with each pixel so the gate matches the bank
   // the pixel was tested against.
   always_ff @(posedge clk) begin
      if (reset) begin
         v1_q          <= 1'b0;
         r1_q          <= 1'b0;
         v2_q          <= 1'b0;
         r2_q          <= 1'b0;
         pattern_vld_q <= 1'b0;
         pattern_in_q  <= 1'b0;
      end else begin
         v1_q          <= bus.pixel_valid;
         r1_q          <= table_ready_q;
         v2_q          <= v1_q;
         r2_q          <= r1_q;
         pattern_vld_q <= v2_q;
         pattern_in_q  <= r2_q & (^hit);
      end
   end

   assign bus.pattern_vld = pattern_vld_q;
   assign bus.pattern_in  = pattern_in_q;

   // ---------------- hit counter ----------------
`ifdef POLY_HIT_COUNT_EN
   logic [COUNT_W-1:0] cnt_q, cnt_d, hc_q;
   logic               hit_now;

   always_comb begin
      hit_now = pattern_vld_q & pattern_in_q;
      cnt_d   = cnt_q;
      // A hit coinciding with frame_sync belongs to the new frame.
      if (bus.frame_sync)
         cnt_d = hit_now ? COUNT_W'(1) : '0;
      else if (hit_now && cnt_q != '1)
         cnt_d = cnt_q + COUNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         hc_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (bus.frame_sync) hc_q <= cnt_q;
      end
   end

   assign bus.hit_count = hc_q;
`else
   assign bus.hit_count = {COUNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_polygon_hit_engine.sv
// tb_polygon_hit_engine: directed stimulus with a scoreboard for pixel
// results and ROM addresses, plus inline load/swap/reset checks.
module tb_polygon_hit_engine;
   localparam int NE  = 4;
   localparam int NP  = 20;
   localparam int CW  = 11;
   localparam int AW  = 10;
   localparam int PN  = 5;
   localparam int CNW = 20;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   polygon_hit_engine_if #(
      .COORD_W(CW), .ROM_AW(AW), .PNUM_W(PN), .COUNT_W(CNW)
   ) bus ();

   polygon_hit_engine #(
      .N_EDGES(NE), .N_PATTERNS(NP), .COORD_W(CW),
      .ROM_AW(AW), .PNUM_W(PN), .COUNT_W(CNW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   logic [4*CW-1:0] rom [0:(1<<AW)-1];
   always @(posedge clk)
      if (bus.p_enable) bus.p_data <= rom[bus.p_addr];

   int checks   = 0;
   int failures = 0;
   int exp_pix[$];
   int exp_addr[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (bus.pattern_vld) begin
         if (exp_pix.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pix_extra actual=vld required=none");
         end else begin
            chk("pattern_in", int'(bus.pattern_in), exp_pix.pop_front());
         end
      end
      if (bus.p_enable) begin
         if (exp_addr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL addr_extra actual=%0d required=none",
                     bus.p_addr);
         end else begin
            chk("p_addr", int'(bus.p_addr), exp_addr.pop_front());
         end
      end
   end

   task automatic set_square(input int p, input int a, input int b);
      int base;
      base = p * NE;
      rom[base+0] = {CW'(a), CW'(a), CW'(b), CW'(a)};
      rom[base+1] = {CW'(b), CW'(a), CW'(b), CW'(b)};
      rom[base+2] = {CW'(b), CW'(b), CW'(a), CW'(b)};
      rom[base+3] = {CW'(a), CW'(b), CW'(a), CW'(a)};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic fsync();
      bus.frame_sync = 1'b1;
      tick();
      bus.frame_sync = 1'b0;
   endtask

   task automatic send(input int x, input int y, input int e);
      bus.x_pixel     = CW'(x);
      bus.y_pixel     = CW'(y);
      bus.pixel_valid = 1'b1;
      exp_pix.push_back(e);
      tick();
      bus.pixel_valid = 1'b0;
   endtask

   task automatic do_load(input int pn, input int eb,
                          input int busy_pn, input bit fs_drain);
      for (int k = 0; k < NE; k++) exp_addr.push_back(eb + k);
      bus.load_req    = 1'b1;
      bus.pattern_num = PN'(pn);
      tick();
      bus.load_req = 1'b0;
      for (int c = 1; c <= NE + 1; c++) begin
         if (c == 2 && busy_pn >= 0) begin
            bus.load_req    = 1'b1;
            bus.pattern_num = PN'(busy_pn);
         end
         if (c == NE + 1) bus.frame_sync = fs_drain;
         @(negedge clk);
         chk("load_busy", int'(bus.load_busy), 1);
         chk("load_done", int'(bus.load_done), (c == NE + 1) ? 1 : 0);
         tick();
         bus.load_req   = 1'b0;
         bus.frame_sync = 1'b0;
      end
      @(negedge clk);
      chk("busy_after", int'(bus.load_busy), 0);
   endtask

   initial begin
      int exp_hc;
      for (int a = 0; a < (1 << AW); a++) rom[a] = '0;
      set_square(0, 10, 60);
      set_square(2, 100, 200);
      set_square(3, 300, 400);
      bus.x_pixel     = '0;
      bus.y_pixel     = '0;
      bus.pixel_valid = 1'b0;
      bus.frame_sync  = 1'b0;
      bus.load_req    = 1'b0;
      bus.pattern_num = '0;
      bus.p_data      = '0;
      reset = 1'b1;
      idle(3);
      @(negedge clk);
      chk("rst_busy", int'(bus.load_busy), 0);
      chk("rst_done", int'(bus.load_done), 0);
      chk("rst_ready", int'(bus.table_ready), 0);
      chk("rst_pen", int'(bus.p_enable), 0);
      chk("rst_vld", int'(bus.pattern_vld), 0);
      chk("rst_in", int'(bus.pattern_in), 0);
      chk("rst_hc", int'(bus.hit_count), 0);
      tick();
      reset = 1'b0;

      // No table yet: inside forced low
      send(150, 150, 0);
      idle(5);

      // Load pattern 2, then swap
      do_load(2, 8, -1, 1'b0);
      chk("ready_preswap", int'(bus.table_ready), 0);
      fsync();
      @(negedge clk);
      chk("ready_swap", int'(bus.table_ready), 1);
      send(150, 150, 1);
      send(50, 150, 0);
      send(250, 150, 0);
      send(150, 100, 1);
      send(150, 200, 0);
      send(100, 150, 1);
      send(200, 150, 0);
      idle(5);

      // Pattern 3 shadowed; busy load_req ignored
      do_load(3, 12, 7, 1'b0);
      send(150, 150, 1);
      send(350, 350, 0);
      fsync();
      send(150, 150, 0);
      send(350, 350, 1);
      idle(5);

      // frame_sync during DRAIN does not swap
      do_load(2, 8, -1, 1'b1);
      send(150, 150, 0);
      send(350, 350, 1);
      fsync();
      send(150, 150, 1);
      idle(5);

      // Out-of-range pattern -> base 0
      do_load(25, 0, -1, 1'b0);
      fsync();
      send(30, 30, 1);
      send(150, 150, 0);
      idle(5);

      // Reset at T+2 of a load, with unscored pixels in flight
      exp_addr.push_back(8);
      exp_addr.push_back(9);
      bus.load_req    = 1'b1;
      bus.pattern_num = PN'(2);
      bus.x_pixel     = CW'(30);
      bus.y_pixel     = CW'(30);
      bus.pixel_valid = 1'b1;
      tick();
      bus.load_req = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.pixel_valid = 1'b0;
      @(negedge clk);
      chk("mid_rst_pen", int'(bus.p_enable), 0);
      chk("mid_rst_ready", int'(bus.table_ready), 0);
      chk("mid_rst_in", int'(bus.pattern_in), 0);
      chk("mid_rst_vld", int'(bus.pattern_vld), 0);
      chk("mid_rst_busy", int'(bus.load_busy), 0);
      send(30, 30, 0);
      idle(5);
      chk("ready_after_rst", int'(bus.table_ready), 0);
      do_load(2, 8, -1, 1'b0);
      fsync();
      send(150, 150, 1);

      // 10x10 in-square block within one frame
      idle(6);
      fsync();
      for (int y = 120; y < 130; y++)
         for (int x = 120; x < 130; x++)
            send(x, y, 1);
      idle(6);
      fsync();
      @(negedge clk);
`ifdef POLY_HIT_COUNT_EN
      exp_hc = 100;
`else
      exp_hc = 0;
`endif
      chk("hit_count", int'(bus.hit_count), exp_hc);
      idle(2);
      fsync();
      @(negedge clk);
      chk("hit_count_empty", int'(bus.hit_count), 0);

      // Drain scoreboard with a bounded wait
      for (int i = 0; i < 20 && exp_pix.size() != 0; i++) tick();
      chk("pix_queue_left", exp_pix.size(), 0);
      chk("addr_queue_left", exp_addr.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
